hazard_ctrl: RTL and testbench

- Pipeline hazard and stall sequencer for the 5-stage CPU.
- Drives the stall enables of the stallable pipeline registers (PC, IF/ID, ID/EX) and the flush/bubble controls of the ID, EX and MEM stages.
- Produces the EX-stage operand forwarding selects.
- Sequences multi-cycle MDU (mul/div) operations with a latency counter FSM so the pipeline is frozen exactly the required number of cycles.

---
 rtl/hazard_pkg.sv | 14 +
 rtl/fwd_sel.sv | 27 ++
 rtl/hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MDU_WAIT,
      MDU_DONE
   } hz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// EX-stage forwarding select for one source operand; the MEM stage wins over WB.
module fwd_sel
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] rsE_i,
   input  logic [REG_ADDR_W-1:0] rdM_i,
   input  logic [REG_ADDR_W-1:0] rdW_i,
   input  logic                  regwriteM_i,
   input  logic                  regwriteW_i,
   output logic [1:0]            forward_o
);

   always_comb begin
      forward_o = FWD_RF;
      // x0 is hardwired to zero and must never be forwarded
      if (rsE_i != '0) begin
         if (regwriteM_i && (rsE_i == rdM_i)) begin
            forward_o = FWD_MEM;
         end else if (regwriteW_i && (rsE_i == rdW_i)) begin
            forward_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall sequencer: forwarding, load-use, branch flush and MDU latency freeze.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned MDU_LATENCY = 4,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned PERF_W      = 32
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic [REG_ADDR_W-1:0] rs1D_i,
   input  logic [REG_ADDR_W-1:0] rs2D_i,
   input  logic [REG_ADDR_W-1:0] rs1E_i,
   input  logic [REG_ADDR_W-1:0] rs2E_i,
   input  logic [REG_ADDR_W-1:0] rdE_i,
   input  logic [REG_ADDR_W-1:0] rdM_i,
   input  logic [REG_ADDR_W-1:0] rdW_i,
   input  logic                  regwriteM_i,
   input  logic                  regwriteW_i,
   input  logic                  loadE_i,
   input  logic                  pcsrcE_i,
   input  logic                  mduStartE_i,
   output logic [1:0]            forwardAE_o,
   output logic [1:0]            forwardBE_o,
   output logic                  stallF_o,
   output logic                  stallD_o,
   output logic                  stallE_o,
   output logic                  flushD_o,
   output logic                  flushE_o,
   output logic                  flushM_o,
   output logic                  mduBusy_o,
   output logic                  mduDone_o,
   output logic [PERF_W-1:0]     stallCnt_o,
   output logic [PERF_W-1:0]     flushCnt_o
);

   hz_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lw_stall;

   fwd_sel #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_a (
      .rsE_i       (rs1E_i),
      .rdM_i       (rdM_i),
      .rdW_i       (rdW_i),
      .regwriteM_i (regwriteM_i),
      .regwriteW_i (regwriteW_i),
      .forward_o   (forwardAE_o)
   );

   fwd_sel #(
      .REG_ADDR_W (REG_ADDR_W)
   ) u_fwd_b (
      .rsE_i       (rs2E_i),
      .rdM_i       (rdM_i),
      .rdW_i       (rdW_i),
      .regwriteM_i (regwriteM_i),
      .regwriteW_i (regwriteW_i),
      .forward_o   (forwardBE_o)
   );

   assign lw_stall = loadE_i && (rdE_i != '0) && ((rs1D_i == rdE_i) || (rs2D_i == rdE_i));

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stallF_o  = 1'b0;
      stallD_o  = 1'b0;
      stallE_o  = 1'b0;
      flushD_o  = 1'b0;
      flushE_o  = 1'b0;
      flushM_o  = 1'b0;
      mduBusy_o = 1'b0;
      mduDone_o = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pcsrcE_i) begin
               flushD_o = 1'b1;
               flushE_o = 1'b1;
            end else if (mduStartE_i) begin
               stallF_o = 1'b1;
               stallD_o = 1'b1;
               stallE_o = 1'b1;
               flushM_o = 1'b1;
               // This cycle is the first frozen one, so WAIT covers LATENCY-1 more
               if (MDU_LATENCY == 1) begin
                  state_d = MDU_DONE;
               end else begin
                  cnt_d   = CNT_W'(MDU_LATENCY - 1);
                  state_d = MDU_WAIT;
               end
            end else if (lw_stall) begin
               stallF_o = 1'b1;
               stallD_o = 1'b1;
               flushE_o = 1'b1;
            end
         end

         MDU_WAIT: begin
            stallF_o  = 1'b1;
            stallD_o  = 1'b1;
            stallE_o  = 1'b1;
            flushM_o  = 1'b1;
            mduBusy_o = 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               cnt_d   = '0;
               state_d = MDU_DONE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         MDU_DONE: begin
            // The MDU op is still in EX here, so mduStartE_i must not retrigger
            mduDone_o = 1'b1;
            state_d   = IDLE;
            if (pcsrcE_i) begin
               flushD_o = 1'b1;
               flushE_o = 1'b1;
            end else if (lw_stall) begin
               stallF_o = 1'b1;
               stallD_o = 1'b1;
               flushE_o = 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stallF_o && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
         end
         if (flushD_o && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + PERF_W'(1);
         end
      end
   end

   assign stallCnt_o = stall_cnt_q;
   assign flushCnt_o = flush_cnt_q;
`else
   assign stallCnt_o = '0;
   assign flushCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: one DUT with MDU latency 4, one with latency 1.
module tb_hazard_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned PW = 32;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic          regwriteM, regwriteW, loadE, pcsrcE, mduStartE;

   logic [1:0]    fa4, fb4, fa1, fb1;
   logic          sf4, sd4, se4, fd4, fe4, fm4, busy4, done4;
   logic          sf1, sd1, se1, fd1, fe1, fm1, busy1, done1;
   logic [PW-1:0] sc4, fc4, sc1, fc1;
   logic [11:0]   o4, o1;

   // Packed as {fwdA, fwdB, stallF, stallD, stallE, flushD, flushE, flushM, busy, done}
   assign o4 = {fa4, fb4, sf4, sd4, se4, fd4, fe4, fm4, busy4, done4};
   assign o1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, fm1, busy1, done1};

   typedef struct {
      string       tag;
      logic [11:0] e4;
      logic [11:0] e1;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   hazard_ctrl #(
      .REG_ADDR_W  (AW),
      .MDU_LATENCY (4),
      .CNT_W       (4),
      .PERF_W      (PW)
   ) dut4 (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .rs1D_i      (rs1D),
      .rs2D_i      (rs2D),
      .rs1E_i      (rs1E),
      .rs2E_i      (rs2E),
      .rdE_i       (rdE),
      .rdM_i       (rdM),
      .rdW_i       (rdW),
      .regwriteM_i (regwriteM),
      .regwriteW_i (regwriteW),
      .loadE_i     (loadE),
      .pcsrcE_i    (pcsrcE),
      .mduStartE_i (mduStartE),
      .forwardAE_o (fa4),
      .forwardBE_o (fb4),
      .stallF_o    (sf4),
      .stallD_o    (sd4),
      .stallE_o    (se4),
      .flushD_o    (fd4),
      .flushE_o    (fe4),
      .flushM_o    (fm4),
      .mduBusy_o   (busy4),
      .mduDone_o   (done4),
      .stallCnt_o  (sc4),
      .flushCnt_o  (fc4)
   );

   hazard_ctrl #(
      .REG_ADDR_W  (AW),
      .MDU_LATENCY (1),
      .CNT_W       (4),
      .PERF_W      (PW)
   ) dut1 (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .rs1D_i      (rs1D),
      .rs2D_i      (rs2D),
      .rs1E_i      (rs1E),
      .rs2E_i      (rs2E),
      .rdE_i       (rdE),
      .rdM_i       (rdM),
      .rdW_i       (rdW),
      .regwriteM_i (regwriteM),
      .regwriteW_i (regwriteW),
      .loadE_i     (loadE),
      .pcsrcE_i    (pcsrcE),
      .mduStartE_i (mduStartE),
      .forwardAE_o (fa1),
      .forwardBE_o (fb1),
      .stallF_o    (sf1),
      .stallD_o    (sd1),
      .stallE_o    (se1),
      .flushD_o    (fd1),
      .flushE_o    (fe1),
      .flushM_o    (fm1),
      .mduBusy_o   (busy1),
      .mduDone_o   (done1),
      .stallCnt_o  (sc1),
      .flushCnt_o  (fc1)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // ctl = {regwriteM, regwriteW, loadE, pcsrcE, mduStartE}
   task automatic vec(input string tag, input logic rst,
                      input logic [AW-1:0] r1d, input logic [AW-1:0] r2d,
                      input logic [AW-1:0] r1e, input logic [AW-1:0] r2e,
                      input logic [AW-1:0] rde, input logic [AW-1:0] rdm,
                      input logic [AW-1:0] rdw, input logic [4:0] ctl,
                      input logic [11:0] e4, input logic [11:0] e1);
      exp_t e;
      @(posedge clk_i);
      #1;
      reset_i = rst;
      rs1D = r1d; rs2D = r2d; rs1E = r1e; rs2E = r2e;
      rdE = rde; rdM = rdm; rdW = rdw;
      {regwriteM, regwriteW, loadE, pcsrcE, mduStartE} = ctl;
      e.tag = tag;
      e.e4  = e4;
      e.e1  = e1;
      sb.push_back(e);
   endtask

   // Outputs are combinational, so compare mid-cycle once inputs have settled
   always @(negedge clk_i) begin
      if (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, "/lat4"}, 32'(o4), 32'(e.e4));
         check({e.tag, "/lat1"}, 32'(o1), 32'(e.e1));
      end
   end

   task automatic check_perf(input string tag);
      check({tag, "/stall4"}, sc4, '0);
      check({tag, "/flush4"}, fc4, '0);
      check({tag, "/stall1"}, sc1, '0);
      check({tag, "/flush1"}, fc1, '0);
   endtask

   localparam logic [11:0] Q = 12'b00_00_000_000_00;

   initial begin
      reset_i = 1'b0;
      rs1D = '0; rs2D = '0; rs1E = '0; rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
      {regwriteM, regwriteW, loadE, pcsrcE, mduStartE} = '0;

      vec("rst", 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, Q);
      @(negedge clk_i);
      #1;
      check_perf("rst_perf");
      reset_i = 1'b1;

      // Forwarding
      vec("fwd_mem",  1, 0, 0, 5, 0, 0, 5, 5, 5'b11000, 12'b10_00_000_000_00, 12'b10_00_000_000_00);
      vec("fwd_wb",   1, 0, 0, 5, 0, 0, 5, 5, 5'b01000, 12'b01_00_000_000_00, 12'b01_00_000_000_00);
      vec("fwd_r0",   1, 0, 0, 0, 5, 0, 5, 5, 5'b11000, 12'b00_10_000_000_00, 12'b00_10_000_000_00);
      vec("fwd_ab",   1, 0, 0, 3, 9, 0, 3, 9, 5'b11000, 12'b10_01_000_000_00, 12'b10_01_000_000_00);
      vec("fwd_none", 1, 0, 0, 4, 6, 0, 3, 9, 5'b11000, Q, Q);

      // Load-use and branch
      vec("ld_rs2",   1, 0, 7, 0, 0, 7, 0, 0, 5'b00100, 12'b00_00_110_010_00, 12'b00_00_110_010_00);
      vec("ld_rs1",   1, 7, 0, 0, 0, 7, 0, 0, 5'b00100, 12'b00_00_110_010_00, 12'b00_00_110_010_00);
      vec("ld_rd0",   1, 0, 0, 0, 0, 0, 0, 0, 5'b00100, Q, Q);
      vec("br_ld",    1, 0, 7, 0, 0, 7, 0, 0, 5'b00110, 12'b00_00_000_110_00, 12'b00_00_000_110_00);
      vec("idle",     1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, Q);

      // MDU start held high for five cycles
      vec("m1_c1", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 12'b00_00_111_001_00, 12'b00_00_111_001_00);
      vec("m1_c2", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 12'b00_00_111_001_10, 12'b00_00_000_000_01);
      vec("m1_c3", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 12'b00_00_111_001_10, 12'b00_00_111_001_00);
      vec("m1_c4", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 12'b00_00_111_001_10, 12'b00_00_000_000_01);
      vec("m1_c5", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 12'b00_00_000_000_01, 12'b00_00_111_001_00);
      vec("m1_c6", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, 12'b00_00_000_000_01);
      vec("m1_c7", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, Q);

      // Branch beats MDU start in IDLE
      vec("br_mdu",  1, 0, 0, 0, 0, 0, 0, 0, 5'b00011, 12'b00_00_000_110_00, 12'b00_00_000_110_00);
      vec("br_mdu2", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, Q);

      // Branch/load-use ignored while frozen, honoured in DONE
      vec("m2_c1", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 12'b00_00_111_001_00, 12'b00_00_111_001_00);
      vec("m2_c2", 1, 0, 7, 0, 0, 7, 0, 0, 5'b00110, 12'b00_00_111_001_10, 12'b00_00_000_110_01);
      vec("m2_c3", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 12'b00_00_111_001_10, Q);
      vec("m2_c4", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 12'b00_00_111_001_10, Q);
      vec("m2_c5", 1, 0, 7, 0, 0, 7, 0, 0, 5'b00100, 12'b00_00_110_010_01, 12'b00_00_110_010_00);
      vec("m2_c6", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, Q);

      // Reset in the middle of an MDU op
      vec("m3_c1",  1, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 12'b00_00_111_001_00, 12'b00_00_111_001_00);
      vec("m3_c2",  1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 12'b00_00_111_001_10, 12'b00_00_000_000_01);
      vec("m3_rst", 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, Q);
      @(negedge clk_i);
      #1;
      check_perf("m3_perf");
      reset_i = 1'b1;
      vec("m3_post", 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, Q, Q);

      @(negedge clk_i);
      #1;
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
